// File: rtl/t05_histogram_rmw_if.sv
// ---------------------------------------------------------------------------
// t05_histogram_rmw_if
//   Groups the symbol stream and the SRAM access port of the histogram
//   engine into one bundle.
//
//   Symbol stream : sym_i, sym_valid_i, sym_ready_o  (valid/ready handshake)
//   SRAM port     : sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o,
//                   sram_rdata_i, sram_ack_i         (req held until ack)
//
//   modport master : the histogram engine (consumes symbols, owns the SRAM port)
//   modport slave  : the environment (symbol source plus SRAM)
// ---------------------------------------------------------------------------
interface t05_histogram_rmw_if #(
    parameter int SYM_W = 8,
    parameter int CNT_W = 32
);
    logic [SYM_W-1:0] sym_i;
    logic             sym_valid_i;
    logic             sym_ready_o;

    logic             sram_req_o;
    logic             sram_we_o;
    logic [SYM_W-1:0] sram_addr_o;
    logic [CNT_W-1:0] sram_wdata_o;
    logic [CNT_W-1:0] sram_rdata_i;
    logic             sram_ack_i;

    modport master (
        input  sym_i, sym_valid_i, sram_rdata_i, sram_ack_i,
        output sym_ready_o, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
    );

    modport slave (
        output sym_i, sym_valid_i, sram_rdata_i, sram_ack_i,
        input  sym_ready_o, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/t05_histogram_rmw.sv
// ---------------------------------------------------------------------------
// t05_histogram_rmw
//   Symbol histogram engine. Each accepted symbol increments its bin, held
//   in external SRAM, through a read-modify-write. Bins saturate at all-ones.
//   Also provides a hardware clear sweep over every bin, an end-of-file
//   symbol that stops the stream, and a running total of counted symbols.
//
// Ports
//   clk         system clock, rising edge
//   nrst        synchronous active-low reset
//   clear_i     request clear of all bins, total_o, eof_o and sat_o
//   bus         symbol handshake plus SRAM port (t05_histogram_rmw_if.master)
//   total_o     non-EOF symbols counted since last clear (saturating)
//   complete_o  one-cycle pulse per finished bin update
//   eof_o       level: EOF symbol seen
//   sat_o       sticky: some bin saturated
//   busy_o      high while clearing or running a read-modify-write
// ---------------------------------------------------------------------------
module t05_histogram_rmw #(
    parameter int               SYM_W          = 8,
    parameter int               CNT_W          = 32,
    parameter int               TOT_W          = 32,
    parameter logic [SYM_W-1:0] EOF_SYM        = 8'h1A,
    parameter bit               CLEAR_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clear_i,
    t05_histogram_rmw_if.master        bus,
    output logic [TOT_W-1:0]           total_o,
    output logic                       complete_o,
    output logic                       eof_o,
    output logic                       sat_o,
    output logic                       busy_o
);

    // ST_RST is a one-cycle quiet state after reset so that every output,
    // including sram_req_o and sym_ready_o, is low in the cycle after nrst.
    typedef enum logic [2:0] {
        ST_RST,
        ST_CLEAR,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [SYM_W-1:0] addr_q, addr_d;      // sweep address in CLEAR, latched symbol in RD/WR
    logic [CNT_W-1:0] rdata_q, rdata_d;    // bin value captured on the read ack
    logic [TOT_W-1:0] total_q, total_d;
    logic             eof_q, eof_d;
    logic             sat_q, sat_d;
    logic             clr_pend_q, clr_pend_d;
    logic             complete_q, complete_d;

    logic             start_clear;
    logic             sym_ready;
    logic             sram_req;
    logic             sram_we;
    logic [CNT_W-1:0] sram_wdata;

    // Saturating increment of the captured bin value; constant during WR,
    // so the write data stays stable while req is held.
    logic             rd_full;
    logic [CNT_W-1:0] bin_inc;

    assign rd_full = (rdata_q == '1);
    assign bin_inc = rd_full ? rdata_q : rdata_q + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its _d signal.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_RST;
            addr_q     <= '0;
            rdata_q    <= '0;
            total_q    <= '0;
            eof_q      <= 1'b0;
            sat_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            total_q    <= total_d;
            eof_q      <= eof_d;
            sat_q      <= sat_d;
            clr_pend_q <= clr_pend_d;
            complete_q <= complete_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        total_d     = total_q;
        eof_d       = eof_q;
        sat_d       = sat_q;
        clr_pend_d  = clr_pend_q;
        complete_d  = 1'b0;
        start_clear = 1'b0;
        sym_ready   = 1'b0;
        sram_req    = 1'b0;
        sram_we     = 1'b0;
        sram_wdata  = '0;

        unique case (state_q)
            ST_RST: begin
                state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            end

            ST_CLEAR: begin
                // clear_i is deliberately ignored: a sweep is already running.
                sram_req = 1'b1;
                sram_we  = 1'b1;
                if (bus.sram_ack_i) begin
                    if (addr_q == '1) begin
                        state_d = ST_IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + SYM_W'(1);
                    end
                end
            end

            ST_IDLE: begin
                // Ready drops with a clear request in the same cycle so that a
                // symbol is never handshaked and then dropped in favour of it.
                sym_ready = !(clear_i || clr_pend_q);
                if (clear_i || clr_pend_q) begin
                    start_clear = 1'b1;
                end else if (bus.sym_valid_i) begin
                    addr_d = bus.sym_i;
                    if (bus.sym_i == EOF_SYM) begin
                        eof_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                sram_req = 1'b1;
                if (clear_i) clr_pend_d = 1'b1;
                if (bus.sram_ack_i) begin
                    rdata_d = bus.sram_rdata_i;
                    state_d = ST_WR;
                end
            end

            ST_WR: begin
                sram_req   = 1'b1;
                sram_we    = 1'b1;
                sram_wdata = bin_inc;
                if (clear_i) clr_pend_d = 1'b1;
                if (bus.sram_ack_i) begin
                    complete_d = 1'b1;
                    sat_d      = sat_q | rd_full;
                    total_d    = (total_q == '1) ? total_q : total_q + TOT_W'(1);
                    state_d    = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (clear_i) start_clear = 1'b1;
            end

            default: begin
                state_d = ST_RST;
            end
        endcase

        // Entering the sweep resets all accumulated status in one place.
        if (start_clear) begin
            state_d    = ST_CLEAR;
            addr_d     = '0;
            total_d    = '0;
            eof_d      = 1'b0;
            sat_d      = 1'b0;
            clr_pend_d = 1'b0;
        end
    end

    assign bus.sym_ready_o  = sym_ready;
    assign bus.sram_req_o   = sram_req;
    assign bus.sram_we_o    = sram_we;
    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_wdata_o = sram_wdata;

    assign total_o    = total_q;
    assign complete_o = complete_q;
    assign eof_o      = eof_q;
    assign sat_o      = sat_q;
    assign busy_o     = (state_q == ST_CLEAR) || (state_q == ST_RD) || (state_q == ST_WR);

endmodule
